// File: rtl/bank_cmd_scheduler_pkg.sv
// Shared definitions for the DRAM command-bus scheduler and the bank FSMs.
// Holds the command encodings and the default DRAM timing constants.
package bank_cmd_scheduler_pkg;

    typedef enum logic [1:0] {
        CMD_ACT = 2'd0,
        CMD_RD  = 2'd1,
        CMD_WR  = 2'd2,
        CMD_PRE = 2'd3
    } cmd_e;

    localparam int DEF_NUM_BANKS = 8;
    localparam int DEF_ADDR_BITS = 14;
    localparam int DEF_T_RCD     = 4;
    localparam int DEF_T_RP      = 4;
    localparam int DEF_T_RAS     = 10;
    localparam int DEF_T_RRD     = 2;
    localparam int DEF_T_CCD     = 2;

    function automatic int max_of5(input int a, input int b, input int c,
                                   input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // Width for a down-counter that must hold values 0..tmax.
    function automatic int cnt_width(input int tmax);
        return (tmax < 1) ? 1 : $clog2(tmax + 1);
    endfunction

endpackage

// File: rtl/bank_cmd_scheduler_if.sv
// Bank-array <-> scheduler connection: per-bank requests, grant/stall
// feedback and the shared registered DRAM command bus.
interface bank_cmd_scheduler_if #(
    parameter int NUM_BANKS = 8,
    parameter int ADDR_BITS = 14
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic                           init_done;
    logic [NUM_BANKS-1:0]           req;
    logic [2*NUM_BANKS-1:0]         req_cmd;
    logic [ADDR_BITS*NUM_BANKS-1:0] req_addr;
    logic [NUM_BANKS-1:0]           stall;
    logic [NUM_BANKS-1:0]           grant;
    logic                           cmd_valid;
    logic [1:0]                     cmd_type;
    logic [BANK_W-1:0]              cmd_bank;
    logic [ADDR_BITS-1:0]           cmd_addr;

    // Bank FSM array side.
    modport master (
        output init_done, req, req_cmd, req_addr,
        input  stall, grant, cmd_valid, cmd_type, cmd_bank, cmd_addr
    );

    // Scheduler side.
    modport slave (
        input  init_done, req, req_cmd, req_addr,
        output stall, grant, cmd_valid, cmd_type, cmd_bank, cmd_addr
    );

endinterface

// File: rtl/bank_cmd_scheduler_timer.sv
// Per-bank DRAM timing windows (tRCD, tRP, tRAS) as saturating down-counters.
// A window is open once its counter has reached zero.
module bank_timer
    import bank_cmd_scheduler_pkg::*;
#(
    parameter int T_RCD = DEF_T_RCD,
    parameter int T_RP  = DEF_T_RP,
    parameter int T_RAS = DEF_T_RAS,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic act_grant,
    input  logic pre_grant,
    output logic act_ok,
    output logic rw_ok,
    output logic pre_ok
);
    localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RAS_LOAD = CNT_W'(T_RAS - 1);

    logic [CNT_W-1:0] rcd_cnt;
    logic [CNT_W-1:0] rp_cnt;
    logic [CNT_W-1:0] ras_cnt;

    // ACT opens both the tRCD (to RD/WR) and tRAS (to PRE) windows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcd_cnt <= '0;
            ras_cnt <= '0;
        end else if (act_grant) begin
            rcd_cnt <= RCD_LOAD;
            ras_cnt <= RAS_LOAD;
        end else begin
            if (rcd_cnt != '0) rcd_cnt <= rcd_cnt - 1'b1;
            if (ras_cnt != '0) ras_cnt <= ras_cnt - 1'b1;
        end
    end

    // PRE opens the tRP window before the next ACT to this bank.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rp_cnt <= '0;
        else if (pre_grant)
            rp_cnt <= RP_LOAD;
        else if (rp_cnt != '0)
            rp_cnt <= rp_cnt - 1'b1;
    end

    assign act_ok = (rp_cnt == '0);
    assign rw_ok  = (rcd_cnt == '0);
    assign pre_ok = (ras_cnt == '0);

endmodule

// File: rtl/bank_cmd_scheduler.sv
// Shared DRAM command-bus scheduler: round-robin grant of one eligible bank
// per cycle, gated by per-bank and bus-wide timing windows, with the winner
// registered onto the command bus one cycle after its grant.
module bank_cmd_scheduler
    import bank_cmd_scheduler_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int T_RCD     = DEF_T_RCD,
    parameter int T_RP      = DEF_T_RP,
    parameter int T_RAS     = DEF_T_RAS,
    parameter int T_RRD     = DEF_T_RRD,
    parameter int T_CCD     = DEF_T_CCD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bank_cmd_scheduler_if.slave  bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int CNT_W  = cnt_width(max_of5(T_RCD, T_RP, T_RAS, T_RRD, T_CCD));
    localparam logic [CNT_W-1:0] RRD_LOAD = CNT_W'(T_RRD - 1);
    localparam logic [CNT_W-1:0] CCD_LOAD = CNT_W'(T_CCD - 1);

    logic [1:0]           cmd_arr  [NUM_BANKS];
    logic [ADDR_BITS-1:0] addr_arr [NUM_BANKS];

    logic [NUM_BANKS-1:0] act_ok, rw_ok, pre_ok;
    logic [NUM_BANKS-1:0] elig;
    logic [NUM_BANKS-1:0] grant_vec;
    logic [NUM_BANKS-1:0] act_grant, pre_grant, rw_grant;

    logic [CNT_W-1:0]  rrd_cnt;
    logic [CNT_W-1:0]  ccd_cnt;
    logic [BANK_W-1:0] ptr;
    logic [BANK_W-1:0] scan_idx;
    logic [BANK_W-1:0] win_idx;
    logic              win_valid;

    logic                 cmd_valid_q;
    logic [1:0]           cmd_type_q;
    logic [BANK_W-1:0]    cmd_bank_q;
    logic [ADDR_BITS-1:0] cmd_addr_q;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        assign cmd_arr[i]  = bus.req_cmd[2*i +: 2];
        assign addr_arr[i] = bus.req_addr[ADDR_BITS*i +: ADDR_BITS];

        bank_timer #(
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS),
            .CNT_W (CNT_W)
        ) u_timer (
            .clk       (clk),
            .rst_n     (rst_n),
            .act_grant (act_grant[i]),
            .pre_grant (pre_grant[i]),
            .act_ok    (act_ok[i]),
            .rw_ok     (rw_ok[i]),
            .pre_ok    (pre_ok[i])
        );

        // Bank i may issue when its own window and the bus-wide window for its command are open.
        always_comb begin
            elig[i] = 1'b0;
            if (rst_n && bus.init_done && bus.req[i]) begin
                case (cmd_arr[i])
                    CMD_ACT: elig[i] = act_ok[i] && (rrd_cnt == '0);
                    CMD_RD,
                    CMD_WR:  elig[i] = rw_ok[i] && (ccd_cnt == '0);
                    default: elig[i] = pre_ok[i];
                endcase
            end
        end

        assign act_grant[i] = grant_vec[i] && (cmd_arr[i] == CMD_ACT);
        assign pre_grant[i] = grant_vec[i] && (cmd_arr[i] == CMD_PRE);
        assign rw_grant[i]  = grant_vec[i] && ((cmd_arr[i] == CMD_RD) || (cmd_arr[i] == CMD_WR));
    end

    // Round-robin scan starting at ptr; the first eligible bank wins, regardless of command type.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int off = 0; off < NUM_BANKS; off++) begin
            scan_idx = ptr + BANK_W'(off);
            if (!win_valid && elig[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // One-hot grant from the arbiter result.
    always_comb begin
        grant_vec = '0;
        if (win_valid) grant_vec[win_idx] = 1'b1;
    end

    // Bus-wide tRRD and tCCD windows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rrd_cnt <= '0;
            ccd_cnt <= '0;
        end else begin
            if (|act_grant)
                rrd_cnt <= RRD_LOAD;
            else if (rrd_cnt != '0)
                rrd_cnt <= rrd_cnt - 1'b1;
            if (|rw_grant)
                ccd_cnt <= CCD_LOAD;
            else if (ccd_cnt != '0)
                ccd_cnt <= ccd_cnt - 1'b1;
        end
    end

    // Pointer moves just past the winner; it holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr <= '0;
        else if (win_valid)
            ptr <= win_idx + BANK_W'(1);
    end

    // Command register: the bus carries the winner one cycle after its grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= '0;
            cmd_bank_q  <= '0;
            cmd_addr_q  <= '0;
        end else begin
            cmd_valid_q <= win_valid;
            if (win_valid) begin
                cmd_type_q <= cmd_arr[win_idx];
                cmd_bank_q <= win_idx;
                cmd_addr_q <= addr_arr[win_idx];
            end
        end
    end

    assign bus.grant     = grant_vec;
    assign bus.stall     = ~grant_vec;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_type  = cmd_type_q;
    assign bus.cmd_bank  = cmd_bank_q;
    assign bus.cmd_addr  = cmd_addr_q;

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Directed scenarios for the command-bus scheduler. Grant timing is checked
// cycle by cycle; every expected bus command is queued when its grant is
// expected and compared when cmd_valid appears.
module tb_bank_cmd_scheduler;
    import bank_cmd_scheduler_pkg::*;

    localparam int NB = 8;
    localparam int AB = 14;

    typedef struct {
        logic [1:0]    typ;
        logic [2:0]    bank;
        logic [AB-1:0] addr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t exp_q[$];
    exp_t mon_e;

    bank_cmd_scheduler_if #(.NUM_BANKS(NB), .ADDR_BITS(AB)) bus ();

    bank_cmd_scheduler #(
        .NUM_BANKS (NB),
        .ADDR_BITS (AB),
        .T_RCD     (4),
        .T_RP      (4),
        .T_RAS     (10),
        .T_RRD     (2),
        .T_CCD     (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; a granted bank leaves its CHECK state and drops its request.
    task automatic tick();
        logic [NB-1:0] g;
        g = bus.grant;
        @(posedge clk);
        #1;
        bus.req = bus.req & ~g;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_req(input int b, input logic [1:0] c, input logic [AB-1:0] a);
        bus.req[b]              = 1'b1;
        bus.req_cmd[2*b +: 2]   = c;
        bus.req_addr[AB*b +: AB] = a;
    endtask

    task automatic push_exp(input logic [1:0] c, input int b, input logic [AB-1:0] a);
        exp_t e;
        e.typ  = c;
        e.bank = 3'(b);
        e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
    endtask

    // Command bus monitor: every strobe must match the oldest expected command.
    always @(negedge clk) begin
        if (bus.cmd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("cmd_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("cmd_type", 32'(bus.cmd_type), 32'(mon_e.typ));
                check_val("cmd_bank", 32'(bus.cmd_bank), 32'(mon_e.bank));
                check_val("cmd_addr", 32'(bus.cmd_addr), 32'(mon_e.addr));
            end
        end
    end

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.init_done = 1'b1;
        bus.req       = '0;
        bus.req_cmd   = '0;
        bus.req_addr  = '0;

        // Reset with every bank requesting: nothing granted, bus registers cleared.
        for (int b = 0; b < NB; b++) set_req(b, CMD_ACT, AB'(b));
        tick();
        tick();
        settle();
        check_val("rst_grant", 32'(bus.grant), 32'h00);
        check_val("rst_stall", 32'(bus.stall), 32'hFF);
        check_val("rst_valid", 32'(bus.cmd_valid), 32'd0);
        check_val("rst_type",  32'(bus.cmd_type), 32'd0);
        check_val("rst_bank",  32'(bus.cmd_bank), 32'd0);
        check_val("rst_addr",  32'(bus.cmd_addr), 32'd0);
        bus.req = '0;
        rst_n   = 1'b1;
        tick();

        // Single bank: ACT at 0, RD asked at 1, granted at 4 (tRCD).
        set_req(2, CMD_ACT, 14'h0123);
        push_exp(CMD_ACT, 2, 14'h0123);
        settle();
        check_val("s1_act_grant", 32'(bus.grant), 32'h04);
        tick();
        set_req(2, CMD_RD, 14'h0040);
        for (int c = 1; c < 4; c++) begin
            settle();
            check_val("s1_rcd_hold", 32'(bus.grant), 32'h00);
            check_val("s1_rcd_stall", 32'(bus.stall[2]), 32'd1);
            tick();
        end
        push_exp(CMD_RD, 2, 14'h0040);
        settle();
        check_val("s1_rd_grant", 32'(bus.grant), 32'h04);
        tick();

        // ACT contention from ptr=0: bank 1 at 0, bank 5 at 2 (tRRD).
        do_reset();
        set_req(1, CMD_ACT, 14'h0011);
        set_req(5, CMD_ACT, 14'h0055);
        push_exp(CMD_ACT, 1, 14'h0011);
        settle();
        check_val("s2_grant0", 32'(bus.grant), 32'h02);
        check_val("s2_stall5_c0", 32'(bus.stall[5]), 32'd1);
        tick();
        settle();
        check_val("s2_grant1", 32'(bus.grant), 32'h00);
        check_val("s2_stall5_c1", 32'(bus.stall[5]), 32'd1);
        tick();
        push_exp(CMD_ACT, 5, 14'h0055);
        settle();
        check_val("s2_grant2", 32'(bus.grant), 32'h20);
        tick();
        // A request withdrawn while blocked by tRRD never reaches the bus.
        set_req(6, CMD_ACT, 14'h0066);
        settle();
        check_val("s2_drop_blk", 32'(bus.grant), 32'h00);
        tick();
        bus.req[6] = 1'b0;
        settle();
        check_val("s2_drop_gone", 32'(bus.grant), 32'h00);
        tick();

        // Round-robin RD from ptr=3, one grant every tCCD=2 cycles.
        do_reset();
        set_req(2, CMD_PRE, 14'h0abc);
        push_exp(CMD_PRE, 2, 14'h0abc);
        settle();
        check_val("s3_pre_grant", 32'(bus.grant), 32'h04);
        tick();
        for (int b = 0; b < NB; b++) set_req(b, CMD_RD, 14'h0100 + AB'(b));
        for (int k = 0; k < NB; k++) begin
            int b;
            b = (3 + k) % NB;
            push_exp(CMD_RD, b, 14'h0100 + AB'(b));
            settle();
            check_val("s3_rr_grant", 32'(bus.grant), 32'(1 << b));
            tick();
            if (k < NB - 1) begin
                settle();
                check_val("s3_rr_gap", 32'(bus.grant), 32'h00);
                tick();
            end
        end

        // tRAS then tRP on bank 3: ACT at 0, PRE at 10, ACT again at 14.
        do_reset();
        set_req(3, CMD_ACT, 14'h0333);
        push_exp(CMD_ACT, 3, 14'h0333);
        settle();
        check_val("s4_act_grant", 32'(bus.grant), 32'h08);
        tick();
        set_req(3, CMD_PRE, 14'h0000);
        for (int c = 1; c < 10; c++) begin
            settle();
            check_val("s4_ras_hold", 32'(bus.grant), 32'h00);
            tick();
        end
        push_exp(CMD_PRE, 3, 14'h0000);
        settle();
        check_val("s4_pre_grant", 32'(bus.grant), 32'h08);
        tick();
        set_req(3, CMD_ACT, 14'h0777);
        for (int c = 11; c < 14; c++) begin
            settle();
            check_val("s4_rp_hold", 32'(bus.grant), 32'h00);
            tick();
        end
        push_exp(CMD_ACT, 3, 14'h0777);
        settle();
        check_val("s4_act2_grant", 32'(bus.grant), 32'h08);
        tick();

        // init_done low blocks grants while timers keep running.
        do_reset();
        set_req(0, CMD_ACT, 14'h0200);
        push_exp(CMD_ACT, 0, 14'h0200);
        settle();
        check_val("s5_act_grant", 32'(bus.grant), 32'h01);
        tick();
        bus.init_done = 1'b0;
        set_req(0, CMD_RD, 14'h00a0);
        for (int b = 1; b < NB; b++) set_req(b, CMD_ACT, 14'h0200 + AB'(b));
        for (int c = 1; c < 5; c++) begin
            settle();
            check_val("s5_init_grant", 32'(bus.grant), 32'h00);
            check_val("s5_init_stall", 32'(bus.stall), 32'hFF);
            if (c > 1) check_val("s5_init_valid", 32'(bus.cmd_valid), 32'd0);
            tick();
        end
        bus.init_done = 1'b1;
        push_exp(CMD_ACT, 1, 14'h0201);
        settle();
        check_val("s5_rise_grant", 32'(bus.grant), 32'h02);
        tick();
        push_exp(CMD_RD, 0, 14'h00a0);
        settle();
        check_val("s5_rd_grant", 32'(bus.grant), 32'h01);
        tick();
        bus.req = '0;
        tick();

        // Reset two cycles after an ACT discards the pending tRCD window.
        do_reset();
        set_req(0, CMD_ACT, 14'h0abc);
        push_exp(CMD_ACT, 0, 14'h0abc);
        settle();
        check_val("s6_act_grant", 32'(bus.grant), 32'h01);
        tick();
        tick();
        rst_n = 1'b0;
        set_req(0, CMD_RD, 14'h0044);
        settle();
        check_val("s6_rst_grant", 32'(bus.grant), 32'h00);
        check_val("s6_rst_stall", 32'(bus.stall), 32'hFF);
        tick();
        rst_n = 1'b1;
        push_exp(CMD_RD, 0, 14'h0044);
        settle();
        check_val("s6_valid_after", 32'(bus.cmd_valid), 32'd0);
        check_val("s6_addr_after", 32'(bus.cmd_addr), 32'd0);
        check_val("s6_rd_grant", 32'(bus.grant), 32'h01);
        tick();
        tick();
        tick();

        check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
